tilt_filter: RTL and testbench
==============================

TILT_FILTER -- requirements
Module: tilt_filter

Interface
REQ-001 Parameter N_LOG2, default 3, log2 of samples averaged per output (N = 8).
REQ-002 Parameter DEADZONE, default 16, magnitude below which an averaged axis is forced to 0.
REQ-003 Parameter SHIFT, default 2, arithmetic right shift applied after deadzone.
REQ-004 Parameter TILT_MAX, default 200, saturation magnitude of tilt outputs.
REQ-005 MAX10_CLK1_50  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sample_valid  in  1  one-cycle strobe; data_x/data_y valid this cycle.
REQ-008 data_x  in  16  signed two's-complement X acceleration from accelerometer stage.
REQ-009 data_y  in  16  signed two's-complement Y acceleration.
REQ-010 frame_start  in  1  one-cycle strobe from VGA stage at start of vertical blanking.
REQ-011 tilt_x  out  10  signed filtered X tilt, stable between publishes.
REQ-012 tilt_y  out  10  signed filtered Y tilt, stable between publishes.
REQ-013 tilt_update  out  1  one-cycle pulse in the cycle tilt_x/tilt_y take new values.
REQ-014 overrun_cnt  out  8  saturating count of averages overwritten before publish.

Function
REQ-015 Accumulators: signed, width 16+N_LOG2 per axis; sample counter 0..N-1; each sample_valid adds sign-extended data to accumulators and increments counter.
REQ-016 On the sample_valid with counter = N-1: sum (including that sample) loads into sum registers; accumulators and counter clear to 0 on the same edge; no sample is ever dropped.
REQ-017 Stage 1 (cycle after sum load): avg = sum >>> N_LOG2 (arithmetic, floor toward -inf), 16-bit.
REQ-018 Stage 2 (next cycle): if -DEADZONE < avg < DEADZONE then 0, else avg >>> SHIFT; result saturated to [-TILT_MAX, +TILT_MAX]; written to pending_x/pending_y and pending flag set.
REQ-019 Latency: 8th sample at cycle t -> pending set at edge ending cycle t+2.
REQ-020 Publish: on frame_start with pending set, tilt_x/tilt_y <= pending values and tilt_update = 1 in the following cycle; pending clears on same edge.
REQ-021 frame_start with pending clear: no change, tilt_update stays 0.
REQ-022 Pending set on the same edge as frame_start arrives: not published; waits for next frame_start.
REQ-023 New stage-2 result while pending still set: pending values overwritten, pending stays set, overrun_cnt increments, saturating at 255.
REQ-024 Publish and new stage-2 result on the same edge: publish uses old pending values; new result becomes pending; no overrun counted.
REQ-025 Stages 1/2 are a 1-deep valid pipeline; back-to-back sums (N=1 config) are processed every cycle without loss.

Reset
REQ-026 reset asserted at a rising edge clears accumulators, counter, sum, pipeline valids, pending, overrun_cnt to 0; tilt_x = tilt_y = 0; tilt_update = 0.
REQ-027 reset mid-accumulation or mid-pipeline discards partial sums and in-flight results; sample_valid/frame_start during reset ignored; first cycle after deassertion is a normal cycle.

Verification
REQ-028 8 samples x=400, y=-400, then frame_start -> tilt_x=100, tilt_y=-100, tilt_update one pulse, overrun_cnt=0.
REQ-029 8 samples x=10, y=-15 (inside deadzone), frame_start -> tilt_x=0, tilt_y=0; x=16 -> tilt_x=4.
REQ-030 8 samples x=2000, y=-8000 -> tilt_x=200, tilt_y=-200 (saturated).
REQ-031 16 samples (two averages: x=400 then x=800) with no frame_start, then frame_start -> tilt_x=200, overrun_cnt=1; frame_start again -> no tilt_update.
REQ-032 frame_start on the exact edge pending sets -> no publish; next frame_start publishes; 4 samples then reset then 8 samples x=400 -> tilt_x=100 (partial discarded).

Source files
------------

// File: rtl/tilt_filter.sv
// Accelerometer tilt filter: block-averages N samples per axis, applies deadzone, shift and
// saturation, then publishes the latest result to the display on the next frame_start strobe.
module tilt_filter #(
  parameter int unsigned N_LOG2   = 3,
  parameter int unsigned DEADZONE = 16,
  parameter int unsigned SHIFT    = 2,
  parameter int unsigned TILT_MAX = 200
) (
  input  logic               MAX10_CLK1_50,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [15:0] data_x,
  input  logic signed [15:0] data_y,
  input  logic               frame_start,
  output logic signed [9:0]  tilt_x,
  output logic signed [9:0]  tilt_y,
  output logic               tilt_update,
  output logic [7:0]         overrun_cnt
);

  localparam int unsigned AccW = 16 + N_LOG2;
  localparam int unsigned CntW = (N_LOG2 > 0) ? N_LOG2 : 1;
  localparam int unsigned NLast = (1 << N_LOG2) - 1;
  localparam logic signed [15:0] DeadZone = 16'(DEADZONE);
  localparam logic signed [15:0] TiltMax  = 16'(TILT_MAX);

  logic signed [AccW-1:0] r_acc_x, r_acc_y, r_sum_x, r_sum_y;
  logic        [CntW-1:0] r_cnt;
  logic                   r_sum_vld;
  logic signed [15:0]     r_avg_x, r_avg_y;
  logic                   r_avg_vld;
  logic signed [9:0]      r_pend_x, r_pend_y;
  logic                   r_pend;
  logic signed [9:0]      r_tilt_x, r_tilt_y;
  logic                   r_update;
  logic        [7:0]      r_overrun;

  logic signed [AccW-1:0] w_acc_nx, w_acc_ny;
  logic                   w_last;
  logic                   w_publish;
  logic signed [9:0]      w_shaped_x, w_shaped_y;

  function automatic logic signed [9:0] f_shape(input logic signed [15:0] a);
    logic signed [15:0] v;
    if ((a > -DeadZone) && (a < DeadZone)) v = '0;
    else                                   v = a >>> SHIFT;
    if (v > TiltMax)       v = TiltMax;
    else if (v < -TiltMax) v = -TiltMax;
    return 10'(v);
  endfunction

  always_comb begin
    w_acc_nx   = r_acc_x + AccW'(data_x);
    w_acc_ny   = r_acc_y + AccW'(data_y);
    w_last     = (r_cnt == CntW'(NLast));
    // Publish only what was already pending before this edge.
    w_publish  = frame_start && r_pend;
    w_shaped_x = f_shape(r_avg_x);
    w_shaped_y = f_shape(r_avg_y);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_cnt     <= '0;
      r_sum_x   <= '0;
      r_sum_y   <= '0;
      r_sum_vld <= 1'b0;
      r_avg_x   <= '0;
      r_avg_y   <= '0;
      r_avg_vld <= 1'b0;
      r_pend_x  <= '0;
      r_pend_y  <= '0;
      r_pend    <= 1'b0;
      r_tilt_x  <= '0;
      r_tilt_y  <= '0;
      r_update  <= 1'b0;
      r_overrun <= '0;
    end else begin
      r_sum_vld <= 1'b0;
      if (sample_valid) begin
        if (w_last) begin
          r_sum_x   <= w_acc_nx;
          r_sum_y   <= w_acc_ny;
          r_sum_vld <= 1'b1;
          r_acc_x   <= '0;
          r_acc_y   <= '0;
          r_cnt     <= '0;
        end else begin
          r_acc_x <= w_acc_nx;
          r_acc_y <= w_acc_ny;
          r_cnt   <= r_cnt + CntW'(1);
        end
      end

      r_avg_vld <= r_sum_vld;
      r_avg_x   <= 16'(r_sum_x >>> N_LOG2);
      r_avg_y   <= 16'(r_sum_y >>> N_LOG2);

      r_update <= w_publish;
      if (w_publish) begin
        r_tilt_x <= r_pend_x;
        r_tilt_y <= r_pend_y;
      end

      if (r_avg_vld) begin
        r_pend_x <= w_shaped_x;
        r_pend_y <= w_shaped_y;
        r_pend   <= 1'b1;
        if (r_pend && !w_publish && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;
      end else if (w_publish) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign tilt_x      = r_tilt_x;
  assign tilt_y      = r_tilt_y;
  assign tilt_update = r_update;
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_tilt_filter.sv
// Self-checking bench for tilt_filter: expected publishes are queued when frame_start is
// driven and popped by a monitor whenever tilt_update pulses.
module tb_tilt_filter;

  logic               clk;
  logic               reset;
  logic               sample_valid;
  logic signed [15:0] data_x, data_y;
  logic               frame_start;
  logic signed [9:0]  tilt_x, tilt_y;
  logic               tilt_update;
  logic [7:0]         overrun_cnt;

  typedef struct packed {
    logic signed [9:0] x;
    logic signed [9:0] y;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  tilt_filter dut (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .data_x       (data_x),
    .data_y       (data_y),
    .frame_start  (frame_start),
    .tilt_x       (tilt_x),
    .tilt_y       (tilt_y),
    .tilt_update  (tilt_update),
    .overrun_cnt  (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  // Every tilt_update pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && tilt_update === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_update: got pulse with x=%0d y=%0d, required no pulse",
                 tilt_x, tilt_y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (tilt_x !== e.x || tilt_y !== e.y) begin
          miscompares++;
          $display("FAIL publish_value: got x=%0d y=%0d, required x=%0d y=%0d",
                   tilt_x, tilt_y, e.x, e.y);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b1;
    frame_start = 1'b1;
    repeat (2) @(negedge clk);
    sample_valid = 1'b0;
    frame_start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic send_samples(input int n, input logic signed [15:0] x,
                              input logic signed [15:0] y);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      data_x = x;
      data_y = y;
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Eight samples with frame_start high exactly on the edge where their result turns pending.
  task automatic send_with_edge_frame(input logic signed [15:0] x, input logic signed [15:0] y);
    send_samples(8, x, y);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_publish(input logic signed [9:0] x, input logic signed [9:0] y);
    int budget;
    exp_t e;
    e.x = x;
    e.y = y;
    sb.push_back(e);
    pulse_frame();
    budget = 6;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_update: got %0d unconsumed publishes, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_overrun(input string name, input logic [7:0] exp);
    vectors++;
    if (overrun_cnt !== exp) begin
      miscompares++;
      $display("FAIL %s: got overrun_cnt=%0d, required %0d", name, overrun_cnt, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tilt_x !== 10'sd0 || tilt_y !== 10'sd0 || tilt_update !== 1'b0 || overrun_cnt !== 8'd0)
    begin
      miscompares++;
      $display("FAIL reset_state: got x=%0d y=%0d upd=%b ovr=%0d, required all 0",
               tilt_x, tilt_y, tilt_update, overrun_cnt);
    end
    reset = 1'b0;
    settle();
  endtask

  task automatic test_basic();
    send_samples(8, 16'sd400, -16'sd400);
    settle();
    expect_publish(10'sd100, -10'sd100);
    check_overrun("basic_overrun", 8'd0);
  endtask

  task automatic test_deadzone();
    send_samples(8, 16'sd10, -16'sd15);
    settle();
    expect_publish(10'sd0, 10'sd0);
    send_samples(8, 16'sd16, -16'sd16);
    settle();
    expect_publish(10'sd4, -10'sd4);
    // -17 averages to -17, floor shift gives -5.
    send_samples(8, -16'sd17, 16'sd15);
    settle();
    expect_publish(-10'sd5, 10'sd0);
  endtask

  task automatic test_saturate();
    send_samples(8, 16'sd2000, -16'sd8000);
    settle();
    expect_publish(10'sd200, -10'sd200);
  endtask

  task automatic test_overrun();
    send_samples(8, 16'sd400, 16'sd0);
    send_samples(8, 16'sd800, 16'sd0);
    settle();
    check_overrun("overrun_one", 8'd1);
    expect_publish(10'sd200, 10'sd0);
    pulse_frame();
    settle();
  endtask

  task automatic test_frame_edge();
    send_with_edge_frame(-16'sd400, 16'sd400);
    settle();
    vectors++;
    if (tilt_x !== 10'sd200 || tilt_y !== 10'sd0) begin
      miscompares++;
      $display("FAIL edge_no_publish: got x=%0d y=%0d, required x=200 y=0", tilt_x, tilt_y);
    end
    expect_publish(-10'sd100, 10'sd100);
  endtask

  task automatic test_reset_mid();
    send_samples(4, 16'sd1000, 16'sd1000);
    do_reset();
    vectors++;
    if (tilt_x !== 10'sd0 || tilt_y !== 10'sd0 || overrun_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid_state: got x=%0d y=%0d ovr=%0d, required 0 0 0",
               tilt_x, tilt_y, overrun_cnt);
    end
    send_samples(8, 16'sd400, -16'sd400);
    settle();
    expect_publish(10'sd100, -10'sd100);
  endtask

  task automatic test_back_to_back();
    // Publish of A and arrival of B on the same edge: A goes out, B stays pending, no overrun.
    send_samples(8, 16'sd400, -16'sd400);
    settle();
    sb.push_back('{x: 10'sd100, y: -10'sd100});
    send_with_edge_frame(-16'sd2000, 16'sd2000);
    settle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL same_edge_publish: got %0d unconsumed, required 0", sb.size());
      sb.delete();
    end
    check_overrun("same_edge_overrun", 8'd0);
    expect_publish(-10'sd200, 10'sd200);
  endtask

  task automatic test_overrun_sat();
    send_samples(8 * 258, 16'sd400, -16'sd400);
    settle();
    check_overrun("overrun_saturate", 8'd255);
    expect_publish(10'sd100, -10'sd100);
    check_overrun("overrun_hold", 8'd255);
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    frame_start = 1'b0;
    data_x = '0;
    data_y = '0;
    test_reset();
    test_basic();
    test_deadzone();
    test_saturate();
    test_overrun();
    test_frame_edge();
    test_reset_mid();
    test_back_to_back();
    test_overrun_sat();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
